// File: rtl/ft600_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing the FT600 mode-245 TX byte path
// between two requesters; each packet is framed as header, length, payload.
module ft600_tx_arbiter #(
    parameter logic [3:0] HDR_MAGIC = 4'hA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ch0_req,
    input  logic [7:0]  ch0_len,
    output logic        ch0_gnt,
    input  logic        ch0_valid,
    input  logic [7:0]  ch0_data,
    output logic        ch0_ready,
    input  logic        ch1_req,
    input  logic [7:0]  ch1_len,
    output logic        ch1_gnt,
    input  logic        ch1_valid,
    input  logic [7:0]  ch1_data,
    output logic        ch1_ready,
    output logic        tx_en,
    output logic [7:0]  tx_in,
    input  logic        tx_full,
    output logic        busy,
    output logic [15:0] pkt_count
);

    typedef enum logic [1:0] {IDLE, HDR, LEN, PAY} state_t;

    state_t      state, state_next;
    logic        cur_ch;
    logic        last_ch;
    logic [8:0]  rem;
    logic [7:0]  len_byte;

    logic        grant;
    logic        grant_ch;
    logic [7:0]  sel_len;
    logic        cur_valid;
    logic        pay_ready;

    assign sel_len = grant_ch ? ch1_len : ch0_len;
    assign busy    = (state != IDLE);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_ch   = 1'b0;
        tx_en      = 1'b0;
        tx_in      = 8'h00;
        ch0_ready  = 1'b0;
        ch1_ready  = 1'b0;
        cur_valid  = cur_ch ? ch1_valid : ch0_valid;
        pay_ready  = 1'b0;

        case (state)
            IDLE: begin
                if (ch0_req || ch1_req) begin
                    grant      = 1'b1;
                    // With both requesting, the channel not served last wins.
                    grant_ch   = (ch0_req && ch1_req) ? ~last_ch : ch1_req;
                    state_next = HDR;
                end
            end
            HDR: begin
                tx_in = {HDR_MAGIC, 3'b000, cur_ch};
                tx_en = !tx_full;
                if (tx_en) state_next = LEN;
            end
            LEN: begin
                tx_in = len_byte;
                tx_en = !tx_full;
                if (tx_en) state_next = PAY;
            end
            PAY: begin
                pay_ready = cur_valid && !tx_full;
                ch0_ready = pay_ready && !cur_ch;
                ch1_ready = pay_ready && cur_ch;
                tx_en     = pay_ready;
                tx_in     = cur_ch ? ch1_data : ch0_data;
                if (tx_en && rem == 9'd1) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_ch    <= 1'b0;
            last_ch   <= 1'b1;
            rem       <= 9'd0;
            len_byte  <= 8'h00;
            ch0_gnt   <= 1'b0;
            ch1_gnt   <= 1'b0;
            pkt_count <= 16'd0;
        end else begin
            state   <= state_next;
            ch0_gnt <= grant && !grant_ch;
            ch1_gnt <= grant && grant_ch;
            if (grant) begin
                cur_ch   <= grant_ch;
                last_ch  <= grant_ch;
                rem      <= (sel_len == 8'd0) ? 9'd256 : {1'b0, sel_len};
                len_byte <= sel_len;
            end
            if (state == PAY && tx_en) begin
                rem <= rem - 9'd1;
                if (rem == 9'd1) pkt_count <= pkt_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ft600_tx_arbiter.sv
// Directed-plus-random bench: a packet-level round-robin model predicts the TX
// byte stream, which is compared against what the arbiter writes.
module tb_ft600_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ch0_req, ch1_req;
    logic [7:0]  ch0_len, ch1_len;
    logic        ch0_gnt, ch1_gnt;
    logic        ch0_valid, ch1_valid;
    logic [7:0]  ch0_data, ch1_data;
    logic        ch0_ready, ch1_ready;
    logic        tx_en;
    logic [7:0]  tx_in;
    logic        tx_full;
    logic        busy;
    logic [15:0] pkt_count;

    always #5 clk = ~clk;

    ft600_tx_arbiter dut (
        .clk(clk), .rst(rst),
        .ch0_req(ch0_req), .ch0_len(ch0_len), .ch0_gnt(ch0_gnt),
        .ch0_valid(ch0_valid), .ch0_data(ch0_data), .ch0_ready(ch0_ready),
        .ch1_req(ch1_req), .ch1_len(ch1_len), .ch1_gnt(ch1_gnt),
        .ch1_valid(ch1_valid), .ch1_data(ch1_data), .ch1_ready(ch1_ready),
        .tx_en(tx_en), .tx_in(tx_in), .tx_full(tx_full),
        .busy(busy), .pkt_count(pkt_count)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] src0_q[$];
    logic [7:0] src1_q[$];
    int         len0_q[$];
    int         len1_q[$];

    int m_last;          // model: channel served most recently
    int m_pkts;          // model: completed packets since reset
    int valid_mode;      // 0 always valid, 1 every other cycle, 2 random
    int full_mode;       // 0 never full, 1 random
    bit stall_en, stall_done;
    int stall_left;
    int cyc;
    int gnt0_cnt, gnt1_cnt;
    bit last_busy;
    bit aborted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit valid_ok();
        case (valid_mode)
            1:       return (cyc % 2) == 0;
            2:       return ($urandom % 3) != 0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic drive_inputs();
        ch0_req   = len0_q.size() > 0;
        ch0_len   = (len0_q.size() > 0) ? len0_q[0][7:0] : 8'h00;
        ch0_data  = (src0_q.size() > 0) ? src0_q[0] : 8'h5A;
        ch0_valid = (src0_q.size() > 0) && valid_ok();
        ch1_req   = len1_q.size() > 0;
        ch1_len   = (len1_q.size() > 0) ? len1_q[0][7:0] : 8'h00;
        ch1_data  = (src1_q.size() > 0) ? src1_q[0] : 8'hA5;
        ch1_valid = (src1_q.size() > 0) && valid_ok();
    endtask

    // One clock: sample away from the edge, then update sources just after it.
    task automatic step();
        logic r0, r1, g0, g1;
        @(negedge clk);
        check("no_write_when_full", tx_en && tx_full, 0);
        check("ready0_legal", ch0_ready && !(ch0_valid && !tx_full), 0);
        check("ready1_legal", ch1_ready && !(ch1_valid && !tx_full), 0);
        check("ready_exclusive", ch0_ready && ch1_ready, 0);
        check("gnt_exclusive", ch0_gnt && ch1_gnt, 0);
        if (tx_en) got_q.push_back(tx_in);
        r0 = ch0_ready; r1 = ch1_ready; g0 = ch0_gnt; g1 = ch1_gnt;
        last_busy = busy;
        @(posedge clk);
        #1;
        if (r0 && src0_q.size() > 0) void'(src0_q.pop_front());
        if (r1 && src1_q.size() > 0) void'(src1_q.pop_front());
        if (g0) begin gnt0_cnt++; if (len0_q.size() > 0) void'(len0_q.pop_front()); end
        if (g1) begin gnt1_cnt++; if (len1_q.size() > 0) void'(len1_q.pop_front()); end
        if (stall_en && !stall_done && got_q.size() == 4) begin
            stall_left = 5;
            stall_done = 1'b1;
        end
        if (stall_left > 0) begin
            tx_full = 1'b1;
            stall_left--;
        end else begin
            tx_full = (full_mode == 1) ? (($urandom % 4) == 0) : 1'b0;
        end
        cyc++;
        drive_inputs();
    endtask

    // Builds the expected stream for n0/n1 packets (len < 0 means random 1..8),
    // then runs the DUT until the stream is complete or the budget runs out.
    task automatic session(input int n0, input int n1, input int l0, input int l1,
                           input int abort_at);
        int p0[$];
        int p1[$];
        int k0, k1, ch, n, budget;
        bit done;
        for (int i = 0; i < n0; i++) p0.push_back(l0 < 0 ? int'($urandom_range(1, 8)) : l0);
        for (int i = 0; i < n1; i++) p1.push_back(l1 < 0 ? int'($urandom_range(1, 8)) : l1);
        exp_q.delete();
        got_q.delete();
        k0 = 0; k1 = 0;
        while (k0 < n0 || k1 < n1) begin
            if (k0 < n0 && k1 < n1) ch = 1 - m_last;
            else                    ch = (k0 < n0) ? 0 : 1;
            m_last = ch;
            n = (ch == 0) ? p0[k0] : p1[k1];
            exp_q.push_back(ch == 0 ? 8'hA0 : 8'hA1);
            exp_q.push_back(n[7:0]);
            if (n == 0) n = 256;
            for (int i = 0; i < n; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                exp_q.push_back(b);
                if (ch == 0) src0_q.push_back(b); else src1_q.push_back(b);
            end
            if (ch == 0) begin len0_q.push_back(p0[k0]); k0++; end
            else         begin len1_q.push_back(p1[k1]); k1++; end
        end
        gnt0_cnt = 0; gnt1_cnt = 0;
        stall_done = 1'b0; stall_left = 0;
        aborted = 1'b0;
        drive_inputs();
        budget = 5000;
        done = 1'b0;
        while (!done && budget > 0) begin
            step();
            budget--;
            if (abort_at > 0 && got_q.size() == abort_at) begin
                aborted = 1'b1;
                return;
            end
            done = got_q.size() >= exp_q.size() && len0_q.size() == 0 &&
                   len1_q.size() == 0 && !last_busy;
        end
        m_pkts += n0 + n1;
        check("session_completed", done, 1);
        check("stream_len", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("stream_byte[%0d]", i), got_q[i], exp_q[i]);
        check("gnt0_pulses", gnt0_cnt, n0);
        check("gnt1_pulses", gnt1_cnt, n1);
        check("pkt_count", pkt_count, m_pkts & 16'hFFFF);
        check("busy_after", busy, 0);
    endtask

    task automatic reset_dut();
        exp_q.delete(); got_q.delete();
        src0_q.delete(); src1_q.delete();
        len0_q.delete(); len1_q.delete();
        rst = 1'b1;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_last = 1;
        m_pkts = 0;
    endtask

    initial begin
        cyc = 0; valid_mode = 0; full_mode = 0;
        stall_en = 1'b0; stall_done = 1'b0; stall_left = 0;
        tx_full = 1'b0;
        m_last = 1; m_pkts = 0;
        rst = 1'b1;
        drive_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_en", tx_en, 0);
        check("rst_tx_in", tx_in, 0);
        check("rst_ch0_gnt", ch0_gnt, 0);
        check("rst_ch1_gnt", ch1_gnt, 0);
        check("rst_ready", {ch0_ready, ch1_ready}, 0);
        check("rst_busy", busy, 0);
        check("rst_pkt_count", pkt_count, 0);
        rst = 1'b0;

        // Single packet of three bytes on channel 0.
        session(1, 0, 3, 0, 0);
        if (got_q.size() >= 2) begin
            check("single_hdr", got_q[0], 8'hA0);
            check("single_len", got_q[1], 8'h03);
        end

        // Simultaneous requests after reset: channel 0 first, then again.
        reset_dut();
        session(1, 1, 2, 2, 0);
        if (got_q.size() > 5) begin
            check("arb_first_hdr", got_q[0], 8'hA0);
            check("arb_second_hdr", got_q[4], 8'hA1);
        end
        session(1, 1, 2, 2, 0);
        if (got_q.size() > 0) check("rereq_first_hdr", got_q[0], 8'hA0);

        // Both channels hold requests across several packets: strict alternation.
        session(4, 4, -1, -1, 0);

        // Five-cycle TX FIFO stall after the second payload byte.
        stall_en = 1'b1;
        session(0, 1, 0, 4, 0);
        stall_en = 1'b0;

        // Length byte 0 (256 bytes) with a source valid every other cycle.
        valid_mode = 1;
        session(1, 0, 0, 0, 0);
        if (got_q.size() >= 2) check("len0_byte", got_q[1], 8'h00);
        check("len0_total", got_q.size(), 258);

        // Randomised traffic with random source stalls and FIFO backpressure.
        valid_mode = 2; full_mode = 1;
        session(3, 3, -1, -1, 0);
        session(2, 5, -1, -1, 0);
        valid_mode = 0; full_mode = 0;

        // Reset in the middle of a 20-byte packet.
        session(1, 0, 20, 0, 11);
        check("abort_reached", aborted, 1);
        rst = 1'b1;
        ch0_valid = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_tx_en", tx_en, 0);
        check("abort_pkt_count", pkt_count, 0);
        rst = 1'b0;
        exp_q.delete(); got_q.delete();
        src0_q.delete(); src1_q.delete();
        len0_q.delete(); len1_q.delete();
        m_last = 1; m_pkts = 0;
        drive_inputs();
        repeat (5) step();
        check("abort_no_residue", got_q.size(), 0);
        session(0, 1, 0, 5, 0);
        if (got_q.size() > 0) check("post_abort_hdr", got_q[0], 8'hA1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
